alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 109 ++++++++++
 tb/tb_alu_exec_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Single-cycle ALU with a two-entry result buffer (head/tail) and valid/ready handshakes.
// Results and flags are computed when an operation is accepted and held until consumed.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       rd_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [4:0]       out_rd_tag
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  // Entry layout: {illegal, zero, tag[4:0], result[WIDTH-1:0]}
  localparam int EW = WIDTH + 7;

  // Returns {illegal, result}; unsupported codes yield a zero result
  function automatic logic [WIDTH:0] alu_eval(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a + b};
      OP_SUB:  r = {1'b0, a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      default: r = {1'b1, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  logic [1:0]     count_r;
  logic [EW-1:0]  head_r;
  logic [EW-1:0]  tail_r;
  logic [WIDTH:0] eval_s;
  logic [EW-1:0]  new_entry_s;
  logic           push_s;
  logic           pop_s;

  assign in_ready    = ~rst & (count_r < 2'd2);
  assign out_valid   = (count_r != 2'd0);
  assign out_result  = head_r[WIDTH-1:0];
  assign out_rd_tag  = head_r[WIDTH+4:WIDTH];
  assign out_zero    = head_r[WIDTH+5];
  assign out_illegal = head_r[WIDTH+6];

  // Evaluate the offered operation and decode the handshakes
  always_comb begin
    eval_s      = alu_eval(alu_control, src_a, src_b);
    new_entry_s = {eval_s[WIDTH], (eval_s[WIDTH-1:0] == {WIDTH{1'b0}}), rd_tag, eval_s[WIDTH-1:0]};
    push_s      = in_valid & in_ready;
    pop_s       = out_valid & out_ready;
  end

  // Buffer update; vacated slots are cleared so idle outputs read as zero
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_r <= 2'd0;
      head_r  <= {EW{1'b0}};
      tail_r  <= {EW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b11: begin
          // Only reachable with one entry: the new entry replaces the departing head
          head_r <= new_entry_s;
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r  <= new_entry_s;
            count_r <= 2'd1;
          end else begin
            tail_r  <= new_entry_s;
            count_r <= 2'd2;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_r  <= tail_r;
            tail_r  <= {EW{1'b0}};
            count_r <= 2'd1;
          end else begin
            head_r  <= {EW{1'b0}};
            count_r <= 2'd0;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized plus directed bench for alu_exec_unit with a queue-based scoreboard.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'b0000;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic [4:0]  rd_tag = 5'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic [4:0]  out_rd_tag;

  typedef struct packed {
    logic        ill;
    logic        zero;
    logic [4:0]  tag;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic pop_pend = 1'b0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .rd_tag(rd_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal),
    .out_rd_tag(out_rd_tag)
  );

  always #5 clk = ~clk;

  // Reference: plain modular arithmetic on wide integers
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] tag);
    exp_t e;
    longint unsigned m;
    m = 64'h1_0000_0000;
    e.tag = tag;
    e.ill = 1'b0;
    case (op)
      4'b0010: e.res = 32'((64'(a) + 64'(b)) % m);
      4'b0110: e.res = 32'((m + 64'(a) - 64'(b)) % m);
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Monitor: compare the presented head against the scoreboard every cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    e = '0;
    if (sb.size() != 0) e = sb[0];
    checks++;
    if (out_valid !== (sb.size() != 0) || in_ready !== (!rst && sb.size() < 2)) begin
      errors++;
      $display("FAIL handshake t=%0t out_valid=%b in_ready=%b required out_valid=%b in_ready=%b",
               $time, out_valid, in_ready, (sb.size() != 0), (!rst && sb.size() < 2));
    end
    checks++;
    if ({out_illegal, out_zero, out_rd_tag, out_result} !== e) begin
      errors++;
      $display("FAIL head t=%0t got ill=%b zero=%b tag=%0d res=%h required ill=%b zero=%b tag=%0d res=%h",
               $time, out_illegal, out_zero, out_rd_tag, out_result, e.ill, e.zero, e.tag, e.res);
    end
    pop_pend = (sb.size() != 0) && out_ready && !flush && !rst;
  end

  always @(posedge clk) begin
    if (pop_pend) begin
      void'(sb.pop_front());
      pop_pend = 1'b0;
    end
  end

  // One cycle of stimulus; the scoreboard is updated just after the edge
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag, input logic ordy,
                      input logic fl, input logic r);
    logic push_pend;
    logic clr_pend;
    exp_t item;
    in_valid = v; alu_control = op; src_a = a; src_b = b; rd_tag = tag;
    out_ready = ordy; flush = fl; rst = r;
    #1;
    item      = model(op, a, b, tag);
    push_pend = v && !r && !fl && (sb.size() < 2);
    clr_pend  = fl || r;
    @(posedge clk);
    #1;
    if (clr_pend) sb.delete();
    else if (push_pend) sb.push_back(item);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", out_result, 32'd0);

    // add 5+7 tag 3
    step(1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", out_result, 32'd12);
    chk("add_zero", {31'd0, out_zero}, 32'd0);
    chk("add_tag", {27'd0, out_rd_tag}, 32'd3);
    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("add_drained", {31'd0, out_valid}, 32'd0);

    // sub producing zero, then borrow wrap (replaces head on push+pop)
    step(1'b1, 4'b0110, 32'd9, 32'd9, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("sub_zero_result", out_result, 32'd0);
    chk("sub_zero_flag", {31'd0, out_zero}, 32'd1);
    step(1'b1, 4'b0110, 32'd0, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("sub_wrap_result", out_result, 32'hFFFF_FFFF);
    chk("sub_wrap_zero", {31'd0, out_zero}, 32'd0);
    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);

    // fill both slots with consumer stalled, third offer ignored
    step(1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 32'h0000_0001, 32'h0000_0002, 5'd2, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 4'b0010, 32'd100, 32'd1, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("full_head", out_result, 32'h0000_F000);
    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("promoted_tail", out_result, 32'h0000_0003);
    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("full_drained", {31'd0, out_valid}, 32'd0);

    // unsupported code
    step(1'b1, 4'b1111, 32'd8, 32'd8, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("illegal_flag", {31'd0, out_illegal}, 32'd1);
    chk("illegal_result", out_result, 32'd0);
    chk("illegal_zero", {31'd0, out_zero}, 32'd1);
    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);

    // flush dominates push and pop
    step(1'b1, 4'b0010, 32'd1, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 32'd2, 32'd2, 5'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 32'd3, 32'd3, 5'd3, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

    // reset mid-operation
    step(1'b1, 4'b0001, 32'd6, 32'd1, 5'd6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = 4'b0010;
        1: op = 4'b0110;
        2: op = 4'b0000;
        3: op = 4'b0001;
        4: op = 4'($urandom_range(0, 15));
        default: op = 4'b0110;
      endcase
      sel = $urandom_range(0, 2);
      a = (sel == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      b = (sel == 1) ? 32'($urandom_range(0, 3)) : ((sel == 2) ? a : $urandom);
      step(1'($urandom_range(0, 1)), op, a, b, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 63) == 0));
    end

    step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
